// File: rtl/dvp_pkg.sv
// Shared types and defaults for the DVP capture front end.
package dvp_pkg;

    localparam int DVP_DEF_COORD_W    = 12;
    localparam int DVP_DEF_FIFO_DEPTH = 16;
    // Width of each crop-window field; COORD_W must not exceed it.
    localparam int DVP_WIN_FIELD_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FRAME = 2'd2,
        DROP  = 2'd3
    } cap_state_t;

    typedef struct packed {
        logic [DVP_WIN_FIELD_W-1:0] x;
        logic [DVP_WIN_FIELD_W-1:0] y;
        logic [DVP_WIN_FIELD_W-1:0] w;
        logic [DVP_WIN_FIELD_W-1:0] h;
    } crop_win_t;

endpackage

// File: rtl/dvp_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on rdata
// whenever empty is low. A write while full is taken only if a read retires
// the head in the same cycle.
module dvp_fifo
    import dvp_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = DVP_DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign rdata = mem[rptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rest) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + (AW+1)'(1);
            if (do_rd) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage array, no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dvp_capture.sv
// DVP camera capture: input registers, frame FSM, beat packer, crop window
// and FWFT output FIFO. Optional statistics outputs are built when
// DVP_CAPTURE_STATS_EN is defined.
module dvp_capture
    import dvp_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int COORD_W       = DVP_DEF_COORD_W,
    parameter int FIFO_DEPTH    = DVP_DEF_FIFO_DEPTH,
    parameter int VSYNC_POL     = 1
) (
    input  logic                              clk,
    input  logic                              rest,
    input  logic                              en,
    input  logic [COORD_W-1:0]                crop_x,
    input  logic [COORD_W-1:0]                crop_y,
    input  logic [COORD_W-1:0]                crop_w,
    input  logic [COORD_W-1:0]                crop_h,
    input  logic                              cam_vsync,
    input  logic                              cam_href,
    input  logic [DATA_W-1:0]                 cam_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_W*BYTES_PER_PIX-1:0]   m_data,
    output logic                              m_sof,
    output logic                              m_eol,
    output logic                              overflow,
    input  logic                              ovf_clear,
    output logic                              busy
`ifdef DVP_CAPTURE_STATS_EN
    ,
    output logic [COORD_W-1:0]                frame_cnt,
    output logic [COORD_W-1:0]                drop_cnt,
    output logic [COORD_W-1:0]                line_pix
`endif
);

    localparam int PIX_W = DATA_W * BYTES_PER_PIX;
    // Crop sums carry one bit beyond the window field, so they cannot wrap.
    localparam int CW1 = DVP_WIN_FIELD_W + 1;
    localparam logic [COORD_W-1:0] COORD_MAX = '1;
    localparam logic [1:0]         LAST_BEAT = 2'(BYTES_PER_PIX - 1);

    logic              vs_p0, vs_d, href_p0, href_d;
    logic [DATA_W-1:0] data_p0;
    logic              frame_start, href_fall;
    cap_state_t        state, state_nxt;
    crop_win_t         win;
    logic [1:0]        beat_cnt;
    logic [PIX_W-1:0]  pack_sr, pack_nxt;
    logic [COORD_W-1:0] x, y;
    logic              pix_done, in_win, at_sof, at_eol;
    logic [CW1-1:0]    x1, y1, cx1, cy1, x_end, y_end;
    logic [PIX_W-1:0]  pix_p1;
    logic              sof_p1, eol_p1, vld_p1;
    logic              fifo_full, fifo_empty, fifo_rd, fifo_wr, ovf_event;
    logic [PIX_W+1:0]  fifo_rdata;

    // Input stage (p0): vsync is normalised so that 1 means "in vsync".
    always_ff @(posedge clk) begin
        if (rest) begin
            vs_p0   <= 1'b0;
            vs_d    <= 1'b0;
            href_p0 <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vs_p0   <= (VSYNC_POL != 0) ? cam_vsync : !cam_vsync;
            vs_d    <= vs_p0;
            href_p0 <= cam_href;
            href_d  <= href_p0;
        end
    end

    // Sensor data register, paired with href_p0.
    always_ff @(posedge clk) begin
        data_p0 <= cam_data;
    end

    assign frame_start = vs_d && !vs_p0;
    assign href_fall   = href_d && !href_p0;

    // State register.
    always_ff @(posedge clk) begin
        if (rest) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; dropping en returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = WAIT;
            WAIT:    if (frame_start) state_nxt = FRAME;
            FRAME:   if (ovf_event) state_nxt = DROP;
            DROP:    if (frame_start) state_nxt = FRAME;
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    // Crop window shadow, loaded on the frame_start that (re)enters FRAME.
    always_ff @(posedge clk) begin
        if (frame_start && state_nxt == FRAME) begin
            win.x <= DVP_WIN_FIELD_W'(crop_x);
            win.y <= DVP_WIN_FIELD_W'(crop_y);
            win.w <= DVP_WIN_FIELD_W'(crop_w);
            win.h <= DVP_WIN_FIELD_W'(crop_h);
        end
    end

    // Beat packer: first beat ends up in the MSBs.
    assign pack_nxt = (pack_sr << DATA_W) | PIX_W'(data_p0);
    assign pix_done = href_p0 && (beat_cnt == LAST_BEAT);

    // Shift register for partial pixels.
    always_ff @(posedge clk) begin
        if (href_p0) pack_sr <= pack_nxt;
    end

    // Beat counter; a partial pixel is abandoned when href drops.
    always_ff @(posedge clk) begin
        if (rest || !href_p0)       beat_cnt <= 2'd0;
        else if (pix_done)          beat_cnt <= 2'd0;
        else                        beat_cnt <= beat_cnt + 2'd1;
    end

    // Pixel/line coordinates; frame_start wins over a coincident line end.
    always_ff @(posedge clk) begin
        if (rest || frame_start) begin
            x <= '0;
            y <= '0;
        end else if (href_fall) begin
            x <= '0;
            if (x != '0 && y != COORD_MAX) y <= y + COORD_W'(1);
        end else if (pix_done && x != COORD_MAX) begin
            x <= x + COORD_W'(1);
        end
    end

    assign x1     = CW1'(x);
    assign y1     = CW1'(y);
    assign cx1    = CW1'(win.x);
    assign cy1    = CW1'(win.y);
    assign x_end  = cx1 + CW1'(win.w);
    assign y_end  = cy1 + CW1'(win.h);
    assign in_win = (x1 >= cx1) && (x1 < x_end) && (y1 >= cy1) && (y1 < y_end);
    assign at_sof = (x1 == cx1) && (y1 == cy1);
    assign at_eol = (x1 == x_end - CW1'(1));

    // Pack/crop stage (p1): completed pixel with its markers.
    always_ff @(posedge clk) begin
        if (pix_done) begin
            pix_p1 <= pack_nxt;
            sof_p1 <= at_sof;
            eol_p1 <= at_eol;
        end
    end

    // Pixel-valid for p1: in-window pixels only, and only while in FRAME.
    always_ff @(posedge clk) begin
        if (rest) vld_p1 <= 1'b0;
        else      vld_p1 <= pix_done && in_win && (state == FRAME);
    end

    assign fifo_rd   = m_valid && m_ready;
    assign ovf_event = vld_p1 && (state == FRAME) && fifo_full && !fifo_rd;
    assign fifo_wr   = vld_p1 && (state == FRAME) && !ovf_event;

    dvp_fifo #(
        .WIDTH (PIX_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rest  (rest),
        .wr    (fifo_wr),
        .wdata ({pix_p1, sof_p1, eol_p1}),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_rdata[PIX_W+1:2] : '0;
    assign m_sof   = m_valid && fifo_rdata[1];
    assign m_eol   = m_valid && fifo_rdata[0];
    assign busy    = (state == FRAME);

    // Sticky overflow flag; a new overflow beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rest)           overflow <= 1'b0;
        else if (ovf_event) overflow <= 1'b1;
        else if (ovf_clear) overflow <= 1'b0;
    end

`ifdef DVP_CAPTURE_STATS_EN
    // Saturating frame/drop/line statistics.
    always_ff @(posedge clk) begin
        if (rest) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
            line_pix  <= '0;
        end else begin
            if (frame_start && state == FRAME && frame_cnt != COORD_MAX)
                frame_cnt <= frame_cnt + COORD_W'(1);
            if (state == FRAME && state_nxt == DROP && drop_cnt != COORD_MAX)
                drop_cnt <= drop_cnt + COORD_W'(1);
            if (href_fall && !frame_start)
                line_pix <= x;
        end
    end
`endif

endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture: a default instance (16-bit pixels) and a
// 3-beat-per-pixel instance, with hand-computed expected pixels.
module tb_dvp_capture;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rest = 1'b1, rest3 = 1'b1;
    logic        en = 1'b0;
    logic [11:0] crop_x = '0, crop_y = '0, crop_w = 12'd4, crop_h = 12'd2;
    logic        cam_vsync = 1'b0, cam_href = 1'b0;
    logic [7:0]  cam_data = '0;
    logic        cam_vsync3 = 1'b0, cam_href3 = 1'b0;
    logic [7:0]  cam_data3 = '0;
    logic        m_ready = 1'b1, ovf_clear = 1'b0;

    logic        m_valid, m_sof, m_eol, overflow, busy;
    logic [15:0] m_data;
    logic        m_valid3, m_sof3, m_eol3, overflow3, busy3;
    logic [23:0] m_data3;

    int checks = 0;
    int failures = 0;

    logic [17:0] q  [$];
    logic [25:0] q3 [$];
    logic [17:0] e;
    logic [25:0] e3;

    dvp_capture u_dut (
        .clk(clk), .rest(rest), .en(en),
        .crop_x(crop_x), .crop_y(crop_y), .crop_w(crop_w), .crop_h(crop_h),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .overflow(overflow),
        .ovf_clear(ovf_clear), .busy(busy)
    );

    dvp_capture #(.BYTES_PER_PIX(3)) u_dut3 (
        .clk(clk), .rest(rest3), .en(en),
        .crop_x(crop_x), .crop_y(crop_y), .crop_w(crop_w), .crop_h(crop_h),
        .cam_vsync(cam_vsync3), .cam_href(cam_href3), .cam_data(cam_data3),
        .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3),
        .m_sof(m_sof3), .m_eol(m_eol3), .overflow(overflow3),
        .ovf_clear(ovf_clear), .busy(busy3)
    );

    // Record every accepted output word.
    always @(posedge clk) begin
        if (m_valid && m_ready)   q.push_back({m_data, m_sof, m_eol});
        if (m_valid3 && m_ready)  q3.push_back({m_data3, m_sof3, m_eol3});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge clk);
        cam_vsync = vs; cam_href = hr; cam_data = d;
    endtask

    task automatic tick3(input logic vs, input logic hr, input logic [7:0] d);
        @(negedge clk);
        cam_vsync3 = vs; cam_href3 = hr; cam_data3 = d;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vsync_pulse();
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        repeat (3) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int nbeats, input int base);
        for (int i = 0; i < nbeats; i++) tick(1'b0, 1'b1, 8'(base + i));
        idle(4);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_sof", 32'(m_sof), 0);
        chk("rst_eol", 32'(m_eol), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        rest = 1'b0; rest3 = 1'b0; en = 1'b1;
        idle(3);
        chk("wait_busy", 32'(busy), 0);
        vsync_pulse();
        chk("frame_busy", 32'(busy), 1);

        // Frame 1: 2 lines x 4 pixels, crop 0/0/4/2, bytes 0x11*k
        q.delete();
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 8'((i + 1) * 17));
            if (i == 2 || i == 3) chk("lat_early", 32'(m_valid), 0);
            if (i == 4) begin
                chk("lat_valid", 32'(m_valid), 1);
                chk("lat_data", 32'(m_data), 32'h1122);
            end
        end
        idle(4);
        for (int i = 8; i < 16; i++) tick(1'b0, 1'b1, 8'((i + 1) * 17));
        idle(8);
        chk("f1_count", 32'(q.size()), 8);
        for (int j = 0; j < 8 && j < q.size(); j++) begin
            e = q[j];
            chk("f1_data", 32'(e[17:2]), 32'({8'((2*j + 1) * 17), 8'((2*j + 2) * 17)}));
            chk("f1_sof", 32'(e[1]), 32'(j == 0));
            chk("f1_eol", 32'(e[0]), 32'(j == 3 || j == 7));
        end

        // Crop x=1 w=2 y=1 h=1 on a 4x3 frame
        crop_x = 12'd1; crop_w = 12'd2; crop_y = 12'd1; crop_h = 12'd1;
        vsync_pulse();
        q.delete();
        for (int l = 0; l < 3; l++) send_line(8, 8'h40 + l * 16);
        idle(4);
        chk("crop_count", 32'(q.size()), 2);
        if (q.size() >= 2) begin
            e = q[0];
            chk("crop_p0", 32'(e[17:2]), 32'h5253);
            chk("crop_p0_sof", 32'(e[1]), 1);
            chk("crop_p0_eol", 32'(e[0]), 0);
            e = q[1];
            chk("crop_p1", 32'(e[17:2]), 32'h5455);
            chk("crop_p1_sof", 32'(e[1]), 0);
            chk("crop_p1_eol", 32'(e[0]), 1);
        end

        // Odd beat count: 5-beat line then an aligned 8-beat line
        crop_x = 12'd0; crop_w = 12'd4; crop_y = 12'd0; crop_h = 12'd2;
        vsync_pulse();
        q.delete();
        send_line(5, 8'h10);
        send_line(8, 8'h20);
        idle(4);
        chk("odd_count", 32'(q.size()), 6);
        if (q.size() >= 6) begin
            e = q[1]; chk("odd_p1", 32'(e[17:2]), 32'h1213);
            e = q[2]; chk("odd_p2", 32'(e[17:2]), 32'h2021);
            e = q[5]; chk("odd_p5", 32'(e[17:2]), 32'h2627);
            chk("odd_p5_eol", 32'(e[0]), 1);
        end

        // Overflow: m_ready low, 20-pixel line into a 16-deep FIFO
        crop_w = 12'd32;
        m_ready = 1'b0;
        vsync_pulse();
        q.delete();
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b1, 8'(i));
            if (i == 34) begin
                chk("ovf_before", 32'(overflow), 0);
                chk("ovf_busy_before", 32'(busy), 1);
            end
            if (i == 38) begin
                chk("ovf_after", 32'(overflow), 1);
                chk("ovf_busy_drop", 32'(busy), 0);
            end
        end
        idle(4);
        chk("ovf_hold_valid", 32'(m_valid), 1);
        chk("ovf_hold_data", 32'(m_data), 32'h0001);
        m_ready = 1'b1;
        idle(20);
        chk("ovf_drain_count", 32'(q.size()), 16);
        for (int j = 0; j < 16 && j < q.size(); j++) begin
            e = q[j];
            chk("ovf_drain_data", 32'(e[17:2]), 32'({8'(2*j), 8'(2*j + 1)}));
        end
        chk("ovf_sticky", 32'(overflow), 1);
        vsync_pulse();
        chk("ovf_resume_busy", 32'(busy), 1);
        q.delete();
        send_line(4, 8'h60);
        idle(4);
        chk("ovf_resume_count", 32'(q.size()), 2);
        if (q.size() >= 1) begin
            e = q[0]; chk("ovf_resume_p0", 32'(e[17:2]), 32'h6061);
        end
        @(negedge clk); ovf_clear = 1'b1;
        @(negedge clk); ovf_clear = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);

        // en dropped and re-asserted mid-frame
        crop_w = 12'd4;
        vsync_pulse();
        q.delete();
        send_line(8, 8'h70);
        en = 1'b0;
        idle(2);
        chk("en_off_busy", 32'(busy), 0);
        en = 1'b1;
        idle(2);
        chk("en_wait_busy", 32'(busy), 0);
        send_line(8, 8'h80);
        idle(4);
        chk("en_count", 32'(q.size()), 4);
        vsync_pulse();
        send_line(8, 8'h90);
        send_line(8, 8'hA0);
        idle(4);
        chk("en_resume_count", 32'(q.size()), 12);
        if (q.size() >= 6) begin
            e = q[4];
            chk("en_resume_p0", 32'(e[17:2]), 32'h9091);
            chk("en_resume_sof", 32'(e[1]), 1);
            e = q[5];
            chk("en_resume_p1_sof", 32'(e[1]), 0);
        end

        // 3-beat pixels with a reset pulse mid-line
        m_ready = 1'b0;
        repeat (3) tick3(1'b1, 1'b0, 8'h00);
        repeat (3) tick3(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) tick3(1'b0, 1'b1, (i % 3 == 0) ? 8'hAA : (i % 3 == 1) ? 8'hBB : 8'hCC);
        chk("b3_pre_valid", 32'(m_valid3), 1);
        chk("b3_pre_data", 32'(m_data3), 32'hAABBCC);
        tick3(1'b0, 1'b1, 8'hAA); rest3 = 1'b1;
        tick3(1'b0, 1'b1, 8'hBB); rest3 = 1'b0;
        chk("b3_rst_valid", 32'(m_valid3), 0);
        chk("b3_rst_data", 32'(m_data3), 0);
        chk("b3_rst_sof", 32'(m_sof3), 0);
        chk("b3_rst_eol", 32'(m_eol3), 0);
        chk("b3_rst_ovf", 32'(overflow3), 0);
        chk("b3_rst_busy", 32'(busy3), 0);
        tick3(1'b0, 1'b1, 8'hCC);
        repeat (3) tick3(1'b0, 1'b0, 8'h00);
        m_ready = 1'b1;
        repeat (3) tick3(1'b1, 1'b0, 8'h00);
        repeat (3) tick3(1'b0, 1'b0, 8'h00);
        q3.delete();
        for (int i = 0; i < 12; i++) tick3(1'b0, 1'b1, (i % 3 == 0) ? 8'hAA : (i % 3 == 1) ? 8'hBB : 8'hCC);
        repeat (8) tick3(1'b0, 1'b0, 8'h00);
        chk("b3_count", 32'(q3.size()), 4);
        for (int j = 0; j < 4 && j < q3.size(); j++) begin
            e3 = q3[j];
            chk("b3_data", 32'(e3[25:2]), 32'hAABBCC);
            chk("b3_sof", 32'(e3[1]), 32'(j == 0));
            chk("b3_eol", 32'(e3[0]), 32'(j == 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvp_capture.md
# dvp_capture

Parametrised DVP camera capture front end and successor to the fixed 8→16-bit OV5640 pixel packer. Runs entirely in the camera pixel-clock domain. It samples the sensor bus, packs BYTES_PER_PIX bytes into one pixel, and crops to a programmable window. Pixels go out through a valid/ready stream with frame and line markers, buffered by an internal FIFO that detects overflow and drops whole frames.

## Interface
Parameters:
- DATA_W, 8: sensor data bus width per beat.
- BYTES_PER_PIX, 2: beats per pixel, range 1..4; pixel width PIX_W = DATA_W*BYTES_PER_PIX.
- COORD_W, 12: width of the x/y counters and crop fields.
- FIFO_DEPTH, 16: output FIFO depth, a power of 2, ≥4.
- VSYNC_POL, 1: 1 = vsync active-high; frame start is the vsync deasserting edge.

Ports:
- clk, in, 1: pixel clock (ov5640_pclk); single clock domain.
- rest, in, 1: synchronous active-high reset.
- en, in, 1: capture enable.
- crop_x, crop_y, in, COORD_W each: window origin in pixels/lines.
- crop_w, crop_h, in, COORD_W each: window size; 0 means the window is empty.
- cam_vsync, in, 1: sensor vsync.
- cam_href, in, 1: sensor href.
- cam_data, in, DATA_W: sensor data.
- m_valid, out, 1: output pixel valid.
- m_ready, in, 1: downstream ready.
- m_data, out, PIX_W: pixel; first beat in the MSBs.
- m_sof, out, 1: marks the first pixel of the window.
- m_eol, out, 1: marks the last pixel of each window line.
- overflow, out, 1: sticky; a pixel was dropped because the FIFO was full.
- ovf_clear, in, 1: clears overflow.
- busy, out, 1: high while the state is FRAME.

## Operation
- Input stage: cam_vsync, cam_href and cam_data are registered once. Edge detection runs on the registered vsync. frame_start is a 1-cycle pulse on the deasserting edge, with polarity set by VSYNC_POL.
- State machine, states IDLE, WAIT, FRAME, DROP:
  - IDLE → WAIT when en=1.
  - Any state → IDLE when en=0. If this happens in FRAME, the partial pixel is discarded and any pixel already in the FIFO is kept.
  - WAIT → FRAME on frame_start.
  - FRAME → DROP on an overflow event.
  - FRAME and DROP → FRAME on the next frame_start. Each frame_start re-arms the crop window.
- crop_x, crop_y, crop_w and crop_h are shadowed on the frame_start that enters or re-enters FRAME. Changes mid-frame take effect at the next frame.
- Packing:
  - The beat counter clears whenever registered href is low.
  - Each href-high beat shifts into the pack register. When the counter reaches BYTES_PER_PIX-1, a pixel is complete and the counter wraps to 0.
  - A partial pixel left when href falls is discarded.
- Coordinates:
  - x counts completed pixels in the line and clears on href fall.
  - y clears on frame_start and increments on an href falling edge, but only if the line produced ≥1 pixel.
  - Both counters saturate at 2^COORD_W-1 with no wrap.
- Crop test, in COORD_W+1-bit arithmetic so the sum cannot overflow:
  - x is in the window when crop_x ≤ x < crop_x+crop_w.
  - y is in the window when crop_y ≤ y < crop_y+crop_h.
  - m_sof = (x==crop_x && y==crop_y).
  - m_eol = (x==crop_x+crop_w-1).
- Only pixels inside the window are written to the FIFO, and only in FRAME.
- Overflow event: an in-window pixel arrives while the FIFO is full and no read happens in the same cycle. The pixel is dropped, overflow is set, and the state goes to DROP.
- A write to a full FIFO with a simultaneous read is accepted.
- ovf_clear clears overflow, except in a cycle that also has an overflow event: there the set wins.
- The FIFO is first-word-fall-through. m_data, m_sof and m_eol are stable while m_valid=1 and m_ready=0.

## Timing
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, overflow=0, busy=0, state IDLE, FIFO empty.
- Reset mid-frame flushes the FIFO; capture restarts at WAIT only after en is seen high.
- Latency: last beat of a pixel on cam_data at edge E0 → registered at E0, packed and crop-tested at E1, FIFO write at E2. With the FIFO previously empty, m_valid is high after E2.
- Throughput is one pixel per BYTES_PER_PIX clocks.
- A transfer occurs on an edge where m_valid=1 and m_ready=1.
- frame_start and the last beat of a line in the same cycle: frame_start takes priority, so counters clear and the line is not counted.

## Configuration
- DVP_CAPTURE_STATS_EN defined: adds three outputs, each COORD_W wide, saturating, and cleared by rest:
  - frame_cnt: frames that completed in FRAME.
  - drop_cnt: frames that entered DROP.
  - line_pix: pixel count of the last full line, including pixels outside the window.
- DVP_CAPTURE_STATS_EN not defined: these outputs and their logic are absent, and the port list ends at busy.

## Structure
- Shared package dvp_pkg holds:
  - the state enum cap_state_t (IDLE, WAIT, FRAME, DROP);
  - a crop-window struct typedef;
  - the default constants for COORD_W and FIFO_DEPTH.
- One sub-module, dvp_fifo: synchronous first-word-fall-through FIFO, PIX_W+2 bits wide, FIFO_DEPTH deep.
- Input stage, state machine, packer and crop logic stay in dvp_capture.

## Test plan
- Defaults, crop 0/0/4/2, m_ready=1; frame of 2 lines × 4 pixels with bytes 0x11,0x22,… → exactly 8 pixels, first 0x1122.
  - m_sof only on pixel 0; m_eol on pixels 3 and 7.
  - First m_valid 3 edges after beat 0x22 is presented.
- Crop x=1, w=2, y=1, h=1 on a 4×3 frame → 2 pixels, both from line 1, x=1 and x=2. m_sof and m_eol on the first and second respectively.
- Odd beat count: href high for 5 beats with BYTES_PER_PIX=2 → 2 pixels; the fifth beat is discarded and the next line starts aligned.
- m_ready=0 with FIFO_DEPTH=16 and a 20-pixel line:
  - overflow=1 after the 17th pixel and busy=0 (state DROP);
  - the FIFO still holds pixels 0–15;
  - the next frame_start resumes capture;
  - ovf_clear then clears overflow.
- en dropped mid-frame and re-asserted mid-frame → no pixels until the next frame_start; m_sof on that frame's first window pixel.
- BYTES_PER_PIX=3, DATA_W=8, rest pulsed for 1 cycle mid-line → all outputs 0 the next cycle; the following frame yields 24-bit pixels 0xAABBCC from beats AA, BB, CC.
